pulse_gen: RTL and testbench

PULSE_GEN -- requirements
Module: pulse_gen

---
 rtl/pulse_gen.sv | 140 ++++++++++++++
 tb/tb_pulse_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_gen.sv
`default_nettype none
// ============================================================================
// pulse_gen : burst pulse generator (PULSE_WIDTH high / GAP low, HOLDOFF dead)
// Rev 1.0   : initial release
// ============================================================================
module pulse_gen #(
  parameter int PULSE_WIDTH = 4,
  parameter int GAP         = 16,
  parameter int HOLDOFF     = 20,
  parameter int MAX_BURST   = 8,
  parameter int CNT_W       = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic             ready,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_count
);

  localparam int c_max_pw_gap = (PULSE_WIDTH > GAP) ? PULSE_WIDTH : GAP;
  localparam int c_max_phase  = (c_max_pw_gap > HOLDOFF) ? c_max_pw_gap : HOLDOFF;
  localparam int c_phase_w    = $clog2(c_max_phase + 1);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_high    = 2'd1;
  localparam logic [1:0] c_st_gap     = 2'd2;
  localparam logic [1:0] c_st_holdoff = 2'd3;

  // Phase counter counts down to zero; load value is phase length minus one.
  localparam logic [c_phase_w-1:0] c_load_high = c_phase_w'(PULSE_WIDTH - 1);
  localparam logic [c_phase_w-1:0] c_load_gap  = c_phase_w'(GAP - 1);
  localparam logic [c_phase_w-1:0] c_load_hold = c_phase_w'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [c_phase_w-1:0] c_phase_one = c_phase_w'(1);
  localparam logic [CNT_W-1:0]     c_cnt_one   = CNT_W'(1);
  localparam logic [CNT_W-1:0]     c_max_burst = CNT_W'(MAX_BURST);

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic [c_phase_w-1:0] r_phase;
  logic [c_phase_w-1:0] w_phase_load;
  logic [CNT_W-1:0]     r_remaining;
  logic [CNT_W-1:0]     r_pulse_count;
  logic                 r_done;
  logic                 w_phase_end;
  logic                 w_accept;
  logic                 w_high_last;
  logic [CNT_W-1:0]     w_len_clamped;

  assign w_phase_end   = (r_phase == '0);
  assign w_accept      = (r_state == c_st_idle) && start && (burst_len != '0);
  assign w_high_last   = (r_state == c_st_high) && w_phase_end;
  assign w_len_clamped = (burst_len > c_max_burst) ? c_max_burst : burst_len;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_phase_load = '0;
    case (r_state)
      c_st_idle: begin
        if (w_accept) begin
          w_state_next = c_st_high;
        end
      end
      c_st_high: begin
        if (w_phase_end) begin
          if (r_remaining > c_cnt_one) begin
            w_state_next = c_st_gap;
          end else if (HOLDOFF == 0) begin
            w_state_next = c_st_idle;
          end else begin
            w_state_next = c_st_holdoff;
          end
        end
      end
      c_st_gap: begin
        if (w_phase_end) begin
          w_state_next = c_st_high;
        end
      end
      c_st_holdoff: begin
        if (w_phase_end) begin
          w_state_next = c_st_idle;
        end
      end
      default: w_state_next = c_st_idle;
    endcase
    case (w_state_next)
      c_st_high:    w_phase_load = c_load_high;
      c_st_gap:     w_phase_load = c_load_gap;
      c_st_holdoff: w_phase_load = c_load_hold;
      default:      w_phase_load = '0;
    endcase
  end

  always_comb begin
    ready = (r_state == c_st_idle);
    busy  = (r_state != c_st_idle);
    out   = (r_state == c_st_high);
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_phase       <= '0;
      r_remaining   <= '0;
      r_pulse_count <= '0;
      r_done        <= 1'b0;
    end else begin
      // done lands on the first IDLE cycle after the burst's last phase.
      r_done <= (r_state != c_st_idle) && (w_state_next == c_st_idle);
      if (w_state_next != r_state) begin
        r_phase <= w_phase_load;
      end else if (!w_phase_end) begin
        r_phase <= r_phase - c_phase_one;
      end
      if (w_accept) begin
        r_remaining   <= w_len_clamped;
        r_pulse_count <= '0;
      end else if (w_high_last) begin
        r_remaining   <= r_remaining - c_cnt_one;
        r_pulse_count <= r_pulse_count + c_cnt_one;
      end
    end
  end

  assign done        = r_done;
  assign pulse_count = r_pulse_count;

endmodule
`default_nettype wire

// File: tb/tb_pulse_gen.sv
`default_nettype none
// ============================================================================
// tb_pulse_gen : scoreboard bench for pulse_gen against a burst timing model
// Rev 1.0      : initial release
// ============================================================================
module tb_pulse_gen;

  localparam int PW = 4;
  localparam int GP = 16;
  localparam int HO = 20;
  localparam int MB = 8;
  localparam int CW = 4;

  typedef struct {
    int cyc;
    int cnt;
  } ev_t;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          start;
  logic [CW-1:0] burst_len;
  logic          ready;
  logic          out;
  logic          busy;
  logic          done;
  logic [CW-1:0] pulse_count;

  int  cyc = 0;
  int  n_pass = 0;
  int  n_total = 0;
  int  last_acc = -1000;
  int  next_ready = 0;
  bit  mon_en = 1'b0;
  bit  skip_ready = 1'b0;
  ev_t rise_q[$];
  ev_t done_q[$];

  pulse_gen #(
    .PULSE_WIDTH(PW),
    .GAP(GP),
    .HOLDOFF(HO),
    .MAX_BURST(MB)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .start(start),
    .burst_len(burst_len),
    .ready(ready),
    .out(out),
    .busy(busy),
    .done(done),
    .pulse_count(pulse_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // Reference model: an accepted burst of n pulses at cycle T produces rises at
  // T+1+i*(PW+GP) and a done strobe after n highs, n-1 gaps and the holdoff.
  task automatic model_step(input bit s, input int len);
    int n;
    int t_done;
    if (n_reset && s && len != 0 && cyc >= next_ready) begin
      n = (len > MB) ? MB : len;
      for (int i = 0; i < n; i++) rise_q.push_back('{cyc + 1 + i * (PW + GP), i});
      t_done = cyc + n * PW + (n - 1) * GP + HO + 1;
      done_q.push_back('{t_done, n});
      last_acc   = cyc;
      next_ready = t_done;
    end
  endtask

  task automatic drive(input bit s, input int len);
    @(posedge clk);
    #1;
    start     = s;
    burst_len = CW'(len);
    model_step(s, len);
  endtask

  task automatic idle_wait();
    int budget = 600;
    while (cyc < next_ready + 1 && budget > 0) begin
      drive(1'b0, 0);
      budget--;
    end
    if (budget == 0) fail("idle_timeout");
  endtask

  // Monitor: pops expectations whenever the DUT shows a rise or a done strobe.
  bit prev_out = 1'b0;
  bit high_active = 1'b0;
  int high_start = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      ev_t e;
      if (!skip_ready) begin
        chk("ready", ready, !((cyc > last_acc) && (cyc < next_ready)));
        chk("busy", busy, (cyc > last_acc) && (cyc < next_ready));
      end
      if (out === 1'b1 && !prev_out) begin
        if (rise_q.size() == 0) fail("out_rise");
        else begin
          e = rise_q.pop_front();
          chk("rise_cycle", cyc, e.cyc);
          chk("count_at_rise", pulse_count, e.cnt);
        end
        high_start  = cyc;
        high_active = 1'b1;
      end
      if (out === 1'b0 && prev_out && high_active) begin
        chk("pulse_width", cyc - high_start, PW);
        high_active = 1'b0;
      end
      if (!n_reset) high_active = 1'b0;
      if (done === 1'b1) begin
        if (done_q.size() == 0) fail("done_strobe");
        else begin
          e = done_q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("done_count", pulse_count, e.cnt);
        end
      end
      prev_out = (out === 1'b1);
    end
  end

  initial begin
    n_reset   = 1'b0;
    start     = 1'b0;
    burst_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", pulse_count, 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    n_reset    = 1'b1;
    next_ready = cyc;

    drive(1'b1, 1);
    idle_wait();
    drive(1'b1, 3);
    idle_wait();
    repeat (10) drive(1'b1, 0);
    idle_wait();
    drive(1'b1, 12);
    for (int i = 0; i < 60; i++) drive($urandom_range(0, 1) == 1, $urandom_range(0, 15));
    idle_wait();
    repeat (75) drive(1'b1, 1);
    idle_wait();

    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 15));
    end
    idle_wait();

    // Abort mid-HIGH: reset sampled at the edge ending cycle T+2.
    drive(1'b1, 3);
    drive(1'b0, 0);
    @(posedge clk);
    #1;
    n_reset    = 1'b0;
    skip_ready = 1'b1;
    rise_q.delete();
    done_q.delete();
    @(posedge clk);
    #1;
    n_reset    = 1'b1;
    last_acc   = -1000;
    next_ready = cyc;
    skip_ready = 1'b0;
    @(negedge clk);
    chk("abort_out", out, 0);
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    repeat (80) drive(1'b0, 0);

    chk("rise_q_empty", rise_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
